// File: rtl/bus_resolver_if.sv
// Bundle of the shared-bus signals between the driver agents and the resolver.
// The resolver takes the slave side; the agents side (or a bench) takes master.
interface bus_resolver_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_DRV = 4,
  parameter int CNT_W   = 8
);
  logic [1:0]               mode;
  logic [NUM_DRV-1:0]       drv_en;
  logic [NUM_DRV*WIDTH-1:0] drv_data;
  logic                     clr_err;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic                     float_flag;
  logic                     contention_flag;
  logic [CNT_W-1:0]         contention_cnt;
  logic [NUM_DRV-1:0]       grant;

  modport master (
    output mode, drv_en, drv_data, clr_err,
    input  bus_out, bus_valid, float_flag, contention_flag, contention_cnt, grant
  );

  modport slave (
    input  mode, drv_en, drv_data, clr_err,
    output bus_out, bus_valid, float_flag, contention_flag, contention_cnt, grant
  );
endinterface

// File: rtl/bus_resolver.sv
// Registered shared-bus resolver: wired-AND, wired-OR, tri-state with contention
// tracking, or round-robin arbitrated ownership, selected per cycle by mode.
module bus_resolver #(
  parameter int WIDTH   = 8,
  parameter int NUM_DRV = 4,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  bus_resolver_if.slave bus
);
  localparam int IDX_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;

  typedef enum logic [1:0] {
    MODE_WAND = 2'd0,
    MODE_WOR  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_ARB  = 2'd3
  } mode_e;

  logic [WIDTH-1:0]   drv_word [NUM_DRV];
  logic [WIDTH-1:0]   and_term [NUM_DRV];
  logic [WIDTH-1:0]   or_term  [NUM_DRV];
  logic [IDX_W-1:0]   rot_idx  [NUM_DRV];
  logic [NUM_DRV-1:0] rot_en;

  logic [WIDTH-1:0]   and_res;
  logic [WIDTH-1:0]   or_res;
  logic               any_en;
  logic               multi_en;
  logic               contention;
  logic [IDX_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   cnt_base;

  logic [WIDTH-1:0]   bus_out_reg,   bus_out_next;
  logic               bus_valid_reg, bus_valid_next;
  logic               float_reg,     float_next;
  logic               cflag_reg,     cflag_next;
  logic [CNT_W-1:0]   ccnt_reg,      ccnt_next;
  logic [NUM_DRV-1:0] grant_reg,     grant_next;
  logic [IDX_W-1:0]   rr_last_reg,   rr_last_next;

  // Disabled drivers contribute the identity of each reduction, so the same
  // AND/OR results serve WAND, WOR and the TRI agreement test.
  // rot_idx[k] is the k-th candidate of the round-robin search after rr_last.
  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_drv
    assign drv_word[gi] = bus.drv_data[gi*WIDTH +: WIDTH];
    assign and_term[gi] = bus.drv_en[gi] ? drv_word[gi] : {WIDTH{1'b1}};
    assign or_term[gi]  = bus.drv_en[gi] ? drv_word[gi] : {WIDTH{1'b0}};
    assign rot_idx[gi]  = IDX_W'((int'(rr_last_reg) + gi + 1) % NUM_DRV);
    assign rot_en[gi]   = bus.drv_en[rot_idx[gi]];
  end

  always_comb begin
    and_res = {WIDTH{1'b1}};
    or_res  = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_DRV; k++) begin
      and_res = and_res & and_term[k];
      or_res  = or_res | or_term[k];
    end
  end

  // Lowest rotated position wins, i.e. the first enabled driver after rr_last.
  always_comb begin
    arb_idx = rot_idx[0];
    for (int k = NUM_DRV - 1; k >= 0; k--) begin
      if (rot_en[k]) arb_idx = rot_idx[k];
    end
  end

  assign any_en     = |bus.drv_en;
  assign multi_en   = |(bus.drv_en & (bus.drv_en - NUM_DRV'(1)));
  // Enabled drivers all agree exactly when their AND equals their OR.
  assign contention = multi_en && (and_res != or_res);
  assign cnt_base   = bus.clr_err ? {CNT_W{1'b0}} : ccnt_reg;

  always_comb begin
    bus_out_next   = bus_out_reg;
    bus_valid_next = 1'b0;
    float_next     = 1'b0;
    grant_next     = '0;
    rr_last_next   = rr_last_reg;
    cflag_next     = bus.clr_err ? 1'b0 : cflag_reg;
    ccnt_next      = cnt_base;

    if (!any_en) begin
      float_next = 1'b1;
    end else begin
      case (mode_e'(bus.mode))
        MODE_WAND: begin
          bus_out_next   = and_res;
          bus_valid_next = 1'b1;
        end
        MODE_WOR: begin
          bus_out_next   = or_res;
          bus_valid_next = 1'b1;
        end
        MODE_TRI: begin
          if (contention) begin
            cflag_next = 1'b1;
            if (cnt_base != {CNT_W{1'b1}}) ccnt_next = cnt_base + CNT_W'(1);
          end else begin
            bus_out_next   = or_res;
            bus_valid_next = 1'b1;
          end
        end
        MODE_ARB: begin
          grant_next[arb_idx] = 1'b1;
          bus_out_next        = drv_word[arb_idx];
          bus_valid_next      = 1'b1;
          rr_last_next        = arb_idx;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out_reg   <= '0;
      bus_valid_reg <= 1'b0;
      float_reg     <= 1'b0;
      cflag_reg     <= 1'b0;
      ccnt_reg      <= '0;
      grant_reg     <= '0;
      rr_last_reg   <= IDX_W'(NUM_DRV - 1);
    end else begin
      bus_out_reg   <= bus_out_next;
      bus_valid_reg <= bus_valid_next;
      float_reg     <= float_next;
      cflag_reg     <= cflag_next;
      ccnt_reg      <= ccnt_next;
      grant_reg     <= grant_next;
      rr_last_reg   <= rr_last_next;
    end
  end

  assign bus.bus_out         = bus_out_reg;
  assign bus.bus_valid       = bus_valid_reg;
  assign bus.float_flag      = float_reg;
  assign bus.contention_flag = cflag_reg;
  assign bus.contention_cnt  = ccnt_reg;
  assign bus.grant           = grant_reg;
endmodule

// File: doc/bus_resolver.md
Name: bus_resolver

Overview:
- Parametrised, clocked successor to our wired-net resolution logic.
- Resolves NUM_DRV independent WIDTH-bit drivers onto one registered shared bus under a runtime-selectable discipline: wired-AND, wired-OR, tri-state with contention detection, or round-robin arbitrated ownership.
- Also reports floating-bus and contention status, with a sticky error flag and a saturating contention counter.
- Sits between on-chip bus agents and any consumer of the shared bus value.

Parameters:
- WIDTH, 8, bit width of each driver and of the bus.
- NUM_DRV, 4, number of drivers (>=2).
- CNT_W, 8, width of the contention counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  0=WAND, 1=WOR, 2=TRI, 3=ARB.
- drv_en  input  NUM_DRV  per-driver enable; bit i qualifies driver i.
- drv_data  input  NUM_DRV*WIDTH  driver i occupies bits [i*WIDTH +: WIDTH].
- clr_err  input  1  clears contention_flag and contention_cnt.
- bus_out  output  WIDTH  registered resolved bus value.
- bus_valid  output  1  bus_out updated with a resolved value this cycle.
- float_flag  output  1  no driver enabled in the sampled cycle.
- contention_flag  output  1  sticky; set on any TRI contention.
- contention_cnt  output  CNT_W  saturating count of TRI contention cycles.
- grant  output  NUM_DRV  one-hot ARB grant; zero outside ARB.

Behaviour:
- Reset is synchronous and active-high; one clock. On rst the outputs are: bus_out=0, bus_valid=0, float_flag=0, contention_flag=0, contention_cnt=0, grant=0, and the round-robin pointer rr_last=NUM_DRV-1, so driver 0 has first priority.
- Reset mid-operation overrides all other inputs in that cycle.
- All outputs are registered. Inputs sampled at edge N appear on outputs after edge N (1-cycle latency).
- No driver enabled (any mode): float_flag=1, bus_valid=0, bus_out holds its previous value, grant=0. Otherwise float_flag=0.
- WAND: bus_out = bitwise AND of data from all enabled drivers. bus_valid=1.
- WOR: bus_out = bitwise OR of data from all enabled drivers. bus_valid=1.
- TRI, exactly one driver enabled: bus_out = that driver's data, bus_valid=1.
- TRI, more than one enabled, all enabled data identical: bus_out = that value, bus_valid=1, no contention.
- TRI, more than one enabled, any enabled data differs: contention cycle.
  - bus_valid=0 and bus_out holds.
  - contention_flag is set.
  - contention_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Contention is detected only in TRI mode. WAND/WOR/ARB never flag it.
- ARB:
  - Search enabled drivers starting at index rr_last+1, wrapping modulo NUM_DRV. The first enabled driver found, g, wins.
  - grant = one-hot(g), bus_out = drv_data[g], bus_valid=1, rr_last=g.
  - A single requester is re-granted every cycle.
  - With no requester, rr_last is unchanged.
- rr_last is updated only in ARB mode. Leaving ARB clears grant on the next edge. Re-entering ARB resumes from the retained rr_last.
- clr_err=1 clears contention_flag and contention_cnt to 0.
- clr_err together with a contention cycle: contention wins, giving contention_flag=1 and contention_cnt=1.
- A mode change takes effect for the cycle in which the new mode is sampled. No draining is required.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, grant=0. First ARB cycle with drv_en=4'b1111 -> grant=4'b0001.
- WAND/WOR (WIDTH=8, NUM_DRV=4): drv_en=4'b0011, data0=8'hF0, data1=8'h3C.
  - mode=0 -> bus_out=8'h30, bus_valid=1 one cycle later.
  - mode=1 -> bus_out=8'hFC.
- TRI:
  - drv_en=4'b0100, data2=8'hA5 -> bus_out=8'hA5, valid=1.
  - Then drv_en=4'b0101, data0=8'h5A -> valid=0, bus_out holds 8'hA5, contention_flag=1, cnt=1.
  - Then data0=8'hA5 -> valid=1, no increment.
- Saturation/clear: CNT_W=2, 5 consecutive contention cycles -> cnt=3 (no wrap).
  - clr_err alone -> flag=0, cnt=0.
  - clr_err together with contention -> flag=1, cnt=1.
- ARB fairness: mode=3, drv_en=4'b1011 held 6 cycles -> grant sequence 0001, 0010, 1000, 0001, 0010, 1000, with bus_out tracking the granted driver's data.
- Float: any mode, drv_en=0 after bus_out=8'h77 -> float_flag=1, bus_valid=0, bus_out stays 8'h77, grant=0.
